// File: rtl/adder_pipe_seg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_seg
// Brief    : Segmented, carry-staggered pipelined add/subtract unit with a
//            valid/ready stream interface and a globally stalled pipeline.
// Revision : 1.0
// ============================================================================
module adder_pipe_seg #(
   parameter int WIDTH = 32,
   parameter int SEGS  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW   = WIDTH / SEGS;
   // Stage k keeps only the WIDTH-k*SW operand-B bits not yet added; all
   // stages' residues are packed back to back into one vector.
   localparam int YTOT = SEGS * WIDTH - SW * SEGS * (SEGS - 1) / 2;

   // r_x rotates right by one segment per stage: the low segment is the next
   // A segment to add, and finished sum segments enter at the top.
   logic [WIDTH-1:0] r_x     [0:SEGS];
   logic [WIDTH-1:0] w_x_nxt [0:SEGS];
   logic [YTOT-1:0]  r_y;
   logic [YTOT-1:0]  w_y_nxt;
   logic [SEGS:0]    r_c,  w_c_nxt;
   logic [SEGS:0]    r_v,  w_v_nxt;
   logic [SEGS:0]    r_am, w_am_nxt;
   logic [SEGS:0]    r_bm, w_bm_nxt;
   logic             w_en;
   logic [WIDTH-1:0] w_bp;

   assign w_en     = !r_v[SEGS] || out_ready;
   assign in_ready = w_en;
   assign w_bp     = sub ? ~b : b;

   assign w_x_nxt[0]          = a;
   assign w_y_nxt[WIDTH-1:0]  = w_bp;
   assign w_c_nxt[0]          = sub;
   assign w_v_nxt[0]          = in_valid;
   assign w_am_nxt[0]         = a[WIDTH-1];
   assign w_bm_nxt[0]         = w_bp[WIDTH-1];

   for (genvar s = 1; s <= SEGS; s++) begin : g_stage
      localparam int YI = (s - 1) * WIDTH - SW * (s - 1) * (s - 2) / 2;
      logic [SW:0] w_add;

      assign w_add = {1'b0, r_x[s-1][SW-1:0]} + {1'b0, r_y[YI +: SW]}
                   + {{SW{1'b0}}, r_c[s-1]};
      assign w_x_nxt[s]  = (r_x[s-1] >> SW) | (WIDTH'(w_add[SW-1:0]) << (WIDTH - SW));
      assign w_c_nxt[s]  = w_add[SW];
      assign w_v_nxt[s]  = r_v[s-1];
      assign w_am_nxt[s] = r_am[s-1];
      assign w_bm_nxt[s] = r_bm[s-1];

      if (s < SEGS) begin : g_fwd
         localparam int YO = s * WIDTH - SW * s * (s - 1) / 2;
         localparam int YW = WIDTH - s * SW;
         assign w_y_nxt[YO +: YW] = r_y[YI + SW +: YW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= SEGS; i++) r_x[i] <= '0;
         r_y  <= '0;
         r_c  <= '0;
         r_v  <= '0;
         r_am <= '0;
         r_bm <= '0;
      end else if (w_en) begin
         for (int i = 0; i <= SEGS; i++) r_x[i] <= w_x_nxt[i];
         r_y  <= w_y_nxt;
         r_c  <= w_c_nxt;
         r_v  <= w_v_nxt;
         r_am <= w_am_nxt;
         r_bm <= w_bm_nxt;
      end
   end

   assign sum       = r_x[SEGS];
   assign cout      = r_c[SEGS];
   assign out_valid = r_v[SEGS];
   assign ovf       = (r_am[SEGS] == r_bm[SEGS]) && (r_x[SEGS][WIDTH-1] != r_am[SEGS]);

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe_seg
// Brief    : Drives three adder_pipe_seg configurations (16/4, 8/1, 8/8) in turn
//            and compares every result against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_adder_pipe_seg;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          stp;
      int          stc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a, b;
   logic        sub;
   logic [2:0]  iv, ordy, ir, ov, co, of;
   logic [15:0] s0;
   logic [7:0]  s1, s2;

   int   tests = 0;
   int   fails = 0;
   int   stp   = 0;
   int   stc   = 0;
   bit   prev_rst = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;

   adder_pipe_seg #(.WIDTH(16), .SEGS(4)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));
   adder_pipe_seg #(.WIDTH(8), .SEGS(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[7:0]), .b(b[7:0]), .sub(sub),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));
   adder_pipe_seg #(.WIDTH(8), .SEGS(8)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a[7:0]), .b(b[7:0]), .sub(sub),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));

   function automatic int wid(int d);
      return (d == 0) ? 16 : 8;
   endfunction

   function automatic int lat(int d);
      return (d == 0) ? 4 : (d == 1) ? 1 : 8;
   endfunction

   function automatic logic [15:0] get_sum(int d);
      return (d == 0) ? s0 : (d == 1) ? {8'h00, s1} : {8'h00, s2};
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(int w, logic [15:0] va, logic [15:0] vb, logic vs);
      exp_t   m;
      longint mk, half, ua, ub, r, sa, sb, sr;
      mk   = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(va) & mk;
      ub   = longint'(vb) & mk;
      r    = vs ? ua - ub : ua + ub;
      m.sum  = 16'(r & mk);
      m.cout = vs ? (ua >= ub) : (r > mk);
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      sr   = vs ? sa - sb : sa + sb;
      m.ovf  = (sr < -half) || (sr >= half);
      m.stp  = 0;
      m.stc  = 0;
      return m;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, expv, stp);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, the rising edge commits.
   task automatic cyc(int d, bit vin, bit rdy, bit r, logic [15:0] va, logic [15:0] vb, logic vs);
      exp_t e;
      @(negedge clk);
      rst  = r;
      iv   = 3'b000;
      iv[d] = vin;
      ordy = 3'b111;
      ordy[d] = rdy;
      a = va; b = vb; sub = vs;
      #1;
      if (r) begin
         q.delete();
         prev_rst = 1'b1;
      end else begin
         if (prev_rst) begin
            chk("rst_out_valid", ov[d], 1'b0);
            chk("rst_sum", get_sum(d), 16'h0);
            chk("rst_cout", co[d], 1'b0);
            chk("rst_ovf", of[d], 1'b0);
            chk("rst_in_ready", ir[d], 1'b1);
            prev_rst = 1'b0;
         end
         chk("in_ready", ir[d], !ov[d] || ordy[d]);
         if (ov[d] && !ordy[d] && q.size() != 0) begin
            chk("hold_sum", get_sum(d), q[0].sum);
            chk("hold_cout", co[d], q[0].cout);
            chk("hold_ovf", of[d], q[0].ovf);
         end
         if (ov[d] && ordy[d]) begin
            if (q.size() == 0) begin
               chk("spurious_out", ov[d], 1'b0);
            end else begin
               e = q.pop_front();
               chk("sum", get_sum(d), e.sum);
               chk("cout", co[d], e.cout);
               chk("ovf", of[d], e.ovf);
               chk("latency", stp, e.stp + lat(d) + 1 + (stc - e.stc));
            end
         end
         if (vin && ir[d]) begin
            e = model(wid(d), va, vb, vs);
            e.stp = stp;
            e.stc = stc;
            q.push_back(e);
         end
         if (!ir[d]) stc++;
      end
      stp++;
   endtask

   task automatic feed_rand(int d, bit rdy);
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      cyc(d, 1'b1, rdy, 1'b0, ra, rb, 1'($urandom));
   endtask

   task automatic drain(int d);
      for (int i = 0; i < 60 && q.size() != 0; i++) cyc(d, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("drain_empty", q.size(), 0);
      repeat (lat(d) + 2) cyc(d, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] mk, half, msb;
      rst = 1'b1; iv = 3'b000; ordy = 3'b111; a = '0; b = '0; sub = 1'b0;
      for (int d = 0; d < 3; d++) begin
         mk   = 16'((32'd1 << wid(d)) - 1);
         half = 16'((32'd1 << (wid(d) / 2)) - 1);
         msb  = 16'(32'd1 << (wid(d) - 1));
         cyc(d, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0);
         cyc(d, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
         // Directed boundary cases: segment carry, full chain, overflow, subtract.
         cyc(d, 1'b1, 1'b1, 1'b0, half, 16'h1, 1'b0);
         cyc(d, 1'b1, 1'b1, 1'b0, mk, 16'h1, 1'b0);
         cyc(d, 1'b1, 1'b1, 1'b0, msb - 16'h1, 16'h1, 1'b0);
         cyc(d, 1'b1, 1'b1, 1'b0, 16'h3, 16'h5, 1'b1);
         cyc(d, 1'b1, 1'b1, 1'b0, msb, 16'h1, 1'b1);
         drain(d);
         repeat (100) feed_rand(d, 1'b1);
         drain(d);
         // Backpressure with a full pipeline and in_valid held high.
         repeat (lat(d) + 3) feed_rand(d, 1'b1);
         repeat (3) feed_rand(d, 1'b0);
         drain(d);
         // Reset with beats in flight; nothing from before may emerge.
         repeat (3) feed_rand(d, 1'b1);
         cyc(d, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
         repeat (lat(d) + 2) cyc(d, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
         feed_rand(d, 1'b1);
         drain(d);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_pipe_seg.md
# adder_pipe_seg

Parametrised, segmented, pipelined add/subtract unit with a valid/ready stream interface. Operands are registered, then the carry ripples one segment per stage through a staggered pipeline, and the result is registered on the output. It is the next-generation timing-characterisation and datapath block for the prefix-adder family. It adds arbitrary width, a configurable pipeline depth, subtract mode, a signed-overflow flag and backpressure, none of which the fixed 8-bit registered wrapper supports.

## Interface
- WIDTH, 32, operand and sum width in bits; must be divisible by SEGS.
- SEGS, 4, number of carry segments, which equals the number of arithmetic pipeline stages; 1 ≤ SEGS ≤ WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0 computes a+b; 1 computes a−b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  signed two's-complement overflow.

## Operation
- Segment width is SW = WIDTH/SEGS. Segment i covers bits [i·SW +: SW].
- **Stage 0 (input register)**
  - On accept, captures a, b' = sub ? ~b : b, and cin = sub, plus a valid bit.
- **Stage s, for s = 1..SEGS**
  - Adds segment s−1 of a and b' together with the carry from stage s−1.
  - Stage 1 uses cin as its carry.
  - Writes the segment result into the lower sum bits.
  - Forwards the carry, the upper un-added operand bits, the already-computed lower sum bits, and a valid bit.
- Stage SEGS feeds the outputs directly: sum, cout and valid.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). Both a[MSB] and b'[MSB] are carried down the pipeline so ovf can be computed at stage SEGS.
- **Flow control (global stall)**
  - en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every pipeline register holds, including all valid bits.
  - When en=1, all stages advance, and bubbles advance as invalid beats.
  - A beat is accepted iff in_valid && in_ready at a rising edge. When in_valid=0 and en=1, stage 0 loads valid=0.
- **Reset**
  - All valid bits clear.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset.
  - Beats in flight when rst is asserted are discarded; no partial result ever appears.
  - rst has priority over en and over in_valid.
- Arithmetic is always modulo 2^WIDTH. There are no saturating modes.

## Timing
- Latency: a beat accepted at edge k appears at the outputs with out_valid=1 after edge k+SEGS, when no stall occurs.
- Register depth is SEGS+1. With SEGS=1, the block is exactly the "register in, add, register out" structure.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid && !out_ready, the sum, cout and ovf outputs are stable and held, and in_ready=0.
- Simultaneous drain and fill in the same cycle (out_ready=1 and in_valid=1 with a full pipeline) is legal, with no bubble inserted.
- The critical combinational path is one SW-bit add plus the carry mux. The en fan-out is combinational from out_ready.

## Test plan
- **Basic add and segment carry** (WIDTH=16, SEGS=4): a=0x00FF, b=0x0001, sub=0 → sum=0x0100, cout=0, ovf=0, out_valid after edge k+4.
- **Full carry chain**: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- **Subtract**: a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- **Back-to-back throughput**: 100 random beats with out_ready=1 and in_valid=1 every cycle → 100 results in order, one per cycle, all matching the reference model, with in_ready held at 1.
- **Backpressure**: deassert out_ready for 3 cycles while 5 beats are in flight → outputs frozen, in_ready=0, and no beat is lost or duplicated after release; results stay in order.
- **Reset mid-stream**: assert rst for 1 cycle with 3 beats in flight → out_valid=0 and sum=0, cout=0, ovf=0 after the edge. None of the 3 beats ever emerges, and the next accepted beat appears exactly SEGS cycles later. Repeat the whole plan with SEGS=1 and WIDTH=8, and with SEGS=WIDTH=8.
